// File: rtl/flit_mux_if.sv
// Flit channel bundle for the two-input flit multiplexer.
// It carries both input ports, the one-hot select and the registered output.
interface flit_mux_if #(
  parameter int DATA_W = 66,
  parameter int VCH_W  = 2,
  parameter int SEL_W  = 5
) ();
  logic [DATA_W-1:0] idata_0;
  logic              ivalid_0;
  logic [VCH_W-1:0]  ivch_0;
  logic [DATA_W-1:0] idata_1;
  logic              ivalid_1;
  logic [VCH_W-1:0]  ivch_1;
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] odata;
  logic              ovalid;
  logic [VCH_W-1:0]  ovch;

  // Upstream side: drives both input channels and the select, observes the output.
  modport master (
    output idata_0, ivalid_0, ivch_0,
    output idata_1, ivalid_1, ivch_1,
    output sel,
    input  odata, ovalid, ovch
  );

  // Multiplexer side.
  modport slave (
    input  idata_0, ivalid_0, ivch_0,
    input  idata_1, ivalid_1, ivch_1,
    input  sel,
    output odata, ovalid, ovch
  );
endinterface

// File: rtl/flit_mux.sv
// Two-input flit multiplexer with a registered output stage.
// A one-hot select picks port 0 or port 1; any other select value emits an
// all-zero, invalid flit. Data and VC pass bit-exact, even when not valid.
module flit_mux #(
  parameter int DATA_W = 66,
  parameter int VCH_W  = 2,
  parameter int SEL_W  = 5
) (
  input logic       clk,
  input logic       rst_,
  flit_mux_if.slave bus
);

  logic              w_sel_0;
  logic              w_sel_1;
  logic [DATA_W-1:0] w_data;
  logic              w_valid;
  logic [VCH_W-1:0]  w_vch;

  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic [VCH_W-1:0]  r_vch;

  // Exact-match decode: zero, high bits or multiple bits all select nothing.
  assign w_sel_0 = (bus.sel == SEL_W'(1));
  assign w_sel_1 = (bus.sel == SEL_W'(2));

  // Pick the next output flit from the selected port, or an empty flit.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    w_data  = '0;
    w_valid = 1'b0;
    w_vch   = '0;
    if (w_sel_0) begin
      w_data  = bus.idata_0;
      w_valid = bus.ivalid_0;
      w_vch   = bus.ivch_0;
    end else if (w_sel_1) begin
      w_data  = bus.idata_1;
      w_valid = bus.ivalid_1;
      w_vch   = bus.ivch_1;
    end
  end

  // Output pipeline register; reset clears it at once, dropping any partial packet.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      // NOTE: non-blocking assignments keep every register update on this edge
      // order-independent; blocking here would create simulation races.
      r_data  <= '0;
      r_valid <= 1'b0;
      r_vch   <= '0;
    end else begin
      r_data  <= w_data;
      r_valid <= w_valid;
      r_vch   <= w_vch;
    end
  end

  assign bus.odata  = r_data;
  assign bus.ovalid = r_valid;
  assign bus.ovch   = r_vch;

endmodule

// File: tb/tb_flit_mux.sv
// Directed self-checking bench for flit_mux: reset, both port selects,
// invalid selects, per-cycle switching and gapped packet traffic.
module tb_flit_mux;
  localparam int DW = 66;
  localparam int VW = 2;
  localparam int SW = 5;

  localparam logic [1:0] T_NONE = 2'd0;
  localparam logic [1:0] T_HEAD = 2'd1;
  localparam logic [1:0] T_DATA = 2'd2;
  localparam logic [1:0] T_TAIL = 2'd3;

  localparam logic [63:0] PAT_A = 64'h0003_FFFF_FFFF_FFF0;
  localparam logic [63:0] PAT_B = 64'h0000_0000_0000_00FF;

  logic clk;
  logic rst_;
  int   checks;
  int   errors;
  int   n_out;

  flit_mux_if #(.DATA_W(DW), .VCH_W(VW), .SEL_W(SW)) bus ();

  flit_mux #(.DATA_W(DW), .VCH_W(VW), .SEL_W(SW)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mk(input logic [1:0] t, input logic [63:0] p);
    return {t, p};
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [DW-1:0] ed,
                       input logic ev, input logic [VW-1:0] ec);
    checks++;
    assert (bus.odata === ed) else begin
      errors++;
      $error("FAIL %s odata: got %h expected %h", tag, bus.odata, ed);
    end
    checks++;
    assert (bus.ovalid === ev) else begin
      errors++;
      $error("FAIL %s ovalid: got %b expected %b", tag, bus.ovalid, ev);
    end
    checks++;
    assert (bus.ovch === ec) else begin
      errors++;
      $error("FAIL %s ovch: got %h expected %h", tag, bus.ovch, ec);
    end
  endtask

  task automatic drive0(input logic [DW-1:0] d, input logic v, input logic [VW-1:0] c);
    bus.idata_0  = d;
    bus.ivalid_0 = v;
    bus.ivch_0   = c;
  endtask

  task automatic drive1(input logic [DW-1:0] d, input logic v, input logic [VW-1:0] c);
    bus.idata_1  = d;
    bus.ivalid_1 = v;
    bus.ivch_1   = c;
  endtask

  initial begin
    logic [DW-1:0] f;
    logic [1:0]    t;
    checks = 0;
    errors = 0;
    n_out  = 0;
    rst_   = 1'b1;
    drive0('0, 1'b0, '0);
    drive1('0, 1'b0, '0);
    bus.sel = '0;

    // Reset from power-up: outputs clear without a clock edge.
    #2 rst_ = 1'b0;
    #1 check("reset_async", '0, 1'b0, 2'd0);
    drive1(mk(T_HEAD, 64'h04), 1'b1, 2'd1);
    bus.sel = 5'b00010;
    tick();
    check("reset_hold", '0, 1'b0, 2'd0);

    // First capture after release, then mid-cycle reset while a flit is shown.
    rst_ = 1'b1;
    tick();
    check("first_capture", mk(T_HEAD, 64'h04), 1'b1, 2'd1);
    #2 rst_ = 1'b0;
    #1 check("reset_midcycle", '0, 1'b0, 2'd0);
    tick();
    check("reset_throughout", '0, 1'b0, 2'd0);
    rst_ = 1'b1;

    // Port 1: HEAD, 20 alternating DATA flits, TAIL, back to back.
    drive0(mk(T_DATA, 64'hDEAD), 1'b1, 2'd1);
    bus.sel = 5'b00010;
    for (int i = 0; i < 22; i++) begin
      if (i == 0)       f = mk(T_HEAD, 64'h0);
      else if (i == 21) f = mk(T_TAIL, 64'h0);
      else              f = mk(T_DATA, (i % 2 == 1) ? PAT_A : PAT_B);
      drive1(f, 1'b1, 2'd2);
      tick();
      check($sformatf("port1_flit%0d", i), f, 1'b1, 2'd2);
    end

    // Port 0 with port 1 carrying other valid data.
    bus.sel = 5'b00001;
    drive0(mk(T_HEAD, 64'h09), 1'b1, 2'd1);
    drive1(mk(T_HEAD, 64'h77), 1'b1, 2'd3);
    tick();
    check("port0_head", mk(T_HEAD, 64'h09), 1'b1, 2'd1);

    // Data and VC forward even when the selected port is not valid.
    drive0(mk(T_DATA, 64'h1234_5678_9ABC_DEF0), 1'b0, 2'd3);
    tick();
    check("port0_invalid_fwd", mk(T_DATA, 64'h1234_5678_9ABC_DEF0), 1'b0, 2'd3);

    // Invalid selects with both inputs valid.
    drive0(mk(T_DATA, 64'hAAAA), 1'b1, 2'd1);
    drive1(mk(T_DATA, 64'hBBBB), 1'b1, 2'd2);
    bus.sel = 5'b00000;
    tick();
    check("sel_zero", '0, 1'b0, 2'd0);
    bus.sel = 5'b00100;
    tick();
    check("sel_bit2", '0, 1'b0, 2'd0);
    bus.sel = 5'b00011;
    tick();
    check("sel_multi", '0, 1'b0, 2'd0);
    bus.sel = 5'b10000;
    tick();
    check("sel_bit4", '0, 1'b0, 2'd0);

    // Per-cycle switching between the ports with fresh data each cycle.
    for (int i = 0; i < 8; i++) begin
      drive0(mk(T_DATA, 64'h1000 + 64'(i)), 1'b1, 2'd1);
      drive1(mk(T_DATA, 64'h2000 + 64'(i)), 1'b1, 2'd2);
      bus.sel = (i % 2 == 0) ? 5'b00001 : 5'b00010;
      tick();
      if (i % 2 == 0)
        check($sformatf("switch%0d", i), mk(T_DATA, 64'h1000 + 64'(i)), 1'b1, 2'd1);
      else
        check($sformatf("switch%0d", i), mk(T_DATA, 64'h2000 + 64'(i)), 1'b1, 2'd2);
    end

    // Gapped traffic on port 1 while port 0 carries unrelated valid flits.
    bus.sel = 5'b00010;
    for (int p = 0; p < 10; p++) begin
      for (int k = 0; k < 20; k++) begin
        t = (k == 0) ? T_HEAD : ((k == 19) ? T_TAIL : T_DATA);
        f = mk(t, {32'(p), 32'(k)});
        drive1(f, 1'b1, 2'(p));
        drive0(mk(T_DATA, 64'(p * 100 + k) ^ 64'hFFFF), 1'b1, 2'(p + 1));
        tick();
        if (bus.ovalid === 1'b1) n_out++;
        check($sformatf("pkt%0d_flit%0d", p, k), f, 1'b1, 2'(p));
      end
      for (int g = 0; g < 7; g++) begin
        drive1(mk(T_NONE, 64'h0), 1'b0, 2'd0);
        tick();
        if (bus.ovalid === 1'b1) n_out++;
        check($sformatf("pkt%0d_gap%0d", p, g), '0, 1'b0, 2'd0);
      end
    end
    checks++;
    assert (n_out == 200) else begin
      errors++;
      $error("FAIL gapped_count: got %0d expected %0d", n_out, 200);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/flit_mux.md
# flit_mux

Two-input flit multiplexer for the NoC router datapath. It forwards one of two input flit channels (data, valid, virtual channel) to a single output channel. The choice is made by a one-hot port-select vector shared with the router's crossbar control. The output is registered, so the block also serves as the pipeline stage after switch allocation and as the unit under energy characterization.

## Interface
Parameters:
- DATA_W, default 66: flit width; bits [DATA_W-1:DATA_W-2] carry the flit type, the remaining 64 bits are payload.
- VCH_W, default 2: virtual-channel ID width.
- SEL_W, default 5: width of the one-hot port-select vector (router port count).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_  input  1  reset, asynchronous, active-low.
- idata_0  input  DATA_W  flit data, input port 0.
- ivalid_0  input  1  flit valid, input port 0.
- ivch_0  input  VCH_W  virtual channel, input port 0.
- idata_1  input  DATA_W  flit data, input port 1.
- ivalid_1  input  1  flit valid, input port 1.
- ivch_1  input  VCH_W  virtual channel, input port 1.
- sel  input  SEL_W  one-hot select: bit0 selects port 0, bit1 selects port 1.
- odata  output  DATA_W  registered output flit data.
- ovalid  output  1  registered output valid.
- ovch  output  VCH_W  registered output virtual channel.

## Operation
- Select decode on the current sel value:
  - sel == 1 (only bit0 set) → port 0.
  - sel == 2 (only bit1 set) → port 1.
  - Any other value (all zero, bits 2..SEL_W-1 set, or more than one bit set) → no port selected.
- Port selected:
  - Next odata and ovch are the selected port's idata and ivch, passed unmodified; the flit type is not interpreted.
  - Next ovalid is the selected port's ivalid.
  - Data and VC are forwarded even when ivalid is 0, so data toggles propagate.
- No port selected: next odata = 0, ovalid = 0, ovch = 0.
- The unselected input has no effect on the outputs.
- No flow control, no buffering beyond the output register, and no flit-type state machine. Packet ordering (HEAD, DATA…, TAIL, NONE) is the upstream source's responsibility.
- Arithmetic: none. All fields are passed bit-exact at full width.

## Timing
- Latency: exactly 1 cycle. Inputs and sel sampled at rising edge N appear on the outputs after edge N, stable until edge N+1.
- Throughput: one flit per cycle, back-to-back, with no bubbles.
- sel may change every cycle. The new value takes effect on the flit sampled at the same edge.
- Reset: when rst_ falls, odata = 0, ovalid = 0 and ovch = 0 immediately, without waiting for a clock edge. Outputs hold these values while rst_ = 0.
- First capture after reset: the first rising edge with rst_ = 1 captures the inputs.
- Reset asserted mid-packet: the outputs clear immediately and the partial packet is dropped. There is no recovery state.
- Simultaneous valid on both inputs: only the selected port is forwarded. The other port is ignored, not queued.

## Test plan
- Reset: drive idata_1 = {HEAD, 32'h0, 32'h04}, ivalid_1 = 1, sel = 5'b00010, assert rst_ = 0 mid-cycle → odata = 0, ovalid = 0 and ovch = 0 immediately and throughout reset.
- Port 1 select:
  - Stimulus: sel = 5'b00010; send HEAD, then 20 DATA flits with the payload alternating between the 50-bit patterns 0x3FFFFFFFFFFF0 and 0x000000000FF; then TAIL.
  - Required: each flit appears on odata exactly 1 cycle later with ovalid = 1, and ovch equals ivch_1.
- Port 0 select: sel = 5'b00001, idata_0 = {HEAD, 32'h0, 32'h09}, ivalid_0 = 1, port 1 carrying different data → odata = {HEAD, 32'h0, 32'h09} and ovalid = 1 after 1 cycle; port 1 values never appear.
- Invalid select: sel = 0, then 5'b00100, then 5'b00011, with both inputs valid → odata = 0, ovalid = 0 and ovch = 0 one cycle after each value.
- Per-cycle switching: toggle sel between 5'b00001 and 5'b00010 every cycle with distinct data on each port → the outputs alternate accordingly with 1-cycle lag and no dropped cycles.
- Gapped traffic: send 10 packets of 20 data flits each, with 7 idle cycles (ivalid = 0, TYPE_NONE) between packets → output flit count and order match the input exactly, and ovalid = 0 during the gaps.
